zxw_alu_sequencer: RTL and testbench
====================================

Name: zxw_alu_sequencer

Overview:
- Issuing side of the 4-bit ALU interface. Accepts one wide operation request (function code plus two W-bit operands) over a valid/ready handshake.
- Drives the 4-bit ALU's fs3..fs0, A and B ports one nibble per cycle, LSB nibble first. Samples the ALU's result and carryout each cycle and chains the carry into the next nibble for arithmetic functions.
- Assembles the W-bit result with carry and zero flags and returns it on an output valid/ready handshake.
- Sits between a control/test front end and the existing combinational ALU, so the 4-bit datapath can do 8/12/16-bit work.

Parameters:
- NIBBLES, 2, number of 4-bit passes per operation; W = 4*NIBBLES; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  sequencer can accept a request.
- in_fs  input  4  function code; bit3 = fs3 (1 = logic, 0 = arithmetic), bit0 = fs0/carry-in.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out_result  output  W  assembled result.
- out_carry  output  1  carryout of the final pass.
- out_zero  output  1  1 when out_result == 0.
- alu_fs3, alu_fs2, alu_fs1, alu_fs0  output  1 each  function select to ALU.
- alu_a  output  4  nibble of A to ALU.
- alu_b  output  4  nibble of B to ALU.
- alu_result  input  4  ALU result (combinational in the same cycle).
- alu_carryout  input  1  ALU carryout.

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset behaviour:
  - State goes to IDLE; nibble counter, carry register and result register clear.
  - out_valid=0, out_result=0, out_carry=0, out_zero=0.
  - All alu_* outputs are 0.
  - in_ready=0 while reset is high.
- IDLE:
  - in_ready=1 and alu_* outputs are 0.
  - On in_valid & in_ready: latch in_fs, in_a and in_b; set idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - alu_a = a_reg[4*idx+3:4*idx] and alu_b = b_reg[4*idx+3:4*idx].
  - alu_fs3..fs1 = fs_reg[3:1].
  - alu_fs0:
    - idx=0: fs_reg[0].
    - idx>0 and fs_reg[3]=0 (arithmetic): carry register, i.e. the previous pass's alu_carryout.
    - idx>0 and fs_reg[3]=1 (logic): fs_reg[0].
  - Each RUN cycle: write alu_result into res_reg nibble idx and alu_carryout into the carry register.
  - If idx==NIBBLES-1, go to DONE; otherwise idx+1.
- DONE:
  - out_valid=1; out_result = res_reg; out_carry = carry register; out_zero = (res_reg==0).
  - alu_* outputs are 0.
  - Outputs hold stable until out_ready; on out_valid & out_ready, go to IDLE.
- Latency: request accepted at edge 0; out_valid is first high in cycle NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles minimum. There is no accept during DONE, even when out_ready is high.
- in_valid while not in IDLE is ignored. Requester must hold the request until in_ready.
- Reset mid-RUN or mid-DONE: operation discarded, IDLE next cycle, no out_valid.
- Operand and fs registers update only on accept, so input changes during RUN have no effect.
- Carry wraps modulo 2^W; overflow beyond the final carry is not reported.

Decomposition:
- Shared package zxw_alu_seq_pkg holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4;
  - FS_LOGIC_BIT=3 and FS_CIN_BIT=0.
- One sub-module, zxw_nibble_sel: a W-bit to 4-bit nibble mux indexed by idx, instantiated twice for alu_a and alu_b.
- The result writeback stays in the top level.

Test Plan:
- Bench ALU stub, used where noted: alu_result = (alu_a + alu_b + alu_fs0)[3:0], alu_carryout = bit 4 of that sum. It gives the exact expected values independent of the real ALU's function map.
- Reset, NIBBLES=2: hold reset 3 cycles, then release -> out_valid=0, out_result=0, all alu_*=0, in_ready=1 in the first cycle after release.
- Add with chaining (stub): in_fs=0000, in_a=0x3C, in_b=0x45 ->
  - RUN idx0: alu_a=C, alu_b=5, fs0=0;
  - RUN idx1: alu_a=3, alu_b=4, fs0=1;
  - out_valid in cycle 3; out_result=0x81, out_carry=0, out_zero=0.
- Wrap and zero (stub): in_fs=0000, in_a=0xFF, in_b=0x01 -> out_result=0x00, out_carry=1, out_zero=1.
- Logic op: in_fs=1010, in_a=0xF0, in_b=0x0F ->
  - alu_fs3..0=1010 on both passes;
  - alu_fs0=0 on idx1 even when the idx0 alu_carryout was 1.
- Backpressure: complete an op with out_ready=0 for 5 cycles, pulsing in_valid meanwhile ->
  - out_* stable, in_ready=0, no second request accepted;
  - out_ready=1 gives IDLE next cycle.
- Reset during RUN idx1 -> next cycle IDLE, in_ready=1, out_valid never asserts, alu_*=0.

Source files
------------

// File: rtl/zxw_alu_seq_pkg.sv
// Shared constants for the nibble-serial ALU sequencer.
package zxw_alu_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned NIBBLE_W     = 4;
  localparam int unsigned FS_LOGIC_BIT = 3;
  localparam int unsigned FS_CIN_BIT   = 0;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } seq_state_e;

endpackage

// File: rtl/zxw_nibble_sel.sv
// Selects one 4-bit nibble out of a wide operand, indexed by pass number.
module zxw_nibble_sel
  import zxw_alu_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NIBBLE_W*NIBBLES-1:0] data,
  input  logic [IDX_W-1:0]            idx,
  output logic [NIBBLE_W-1:0]         nib
);

  // Plain mux; out-of-range indices yield zero
  always_comb begin
    nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) nib = data[i*NIBBLE_W +: NIBBLE_W];
    end
  end

endmodule

// File: rtl/zxw_alu_sequencer.sv
// Drives a 4-bit combinational ALU one nibble per cycle to perform W-bit
// operations, chaining carry between passes for arithmetic functions.
module zxw_alu_sequencer
  import zxw_alu_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 2,
  localparam int unsigned W      = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_fs,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        out_result,
  output logic                out_carry,
  output logic                out_zero,
  output logic                alu_fs3,
  output logic                alu_fs2,
  output logic                alu_fs1,
  output logic                alu_fs0,
  output logic [NIBBLE_W-1:0] alu_a,
  output logic [NIBBLE_W-1:0] alu_b,
  input  logic [NIBBLE_W-1:0] alu_result,
  input  logic                alu_carryout
);

  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  seq_state_e          state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [3:0]          fs_reg;
  logic [W-1:0]        a_reg, b_reg, res_reg;
  logic                carry_reg;
  logic [NIBBLE_W-1:0] sel_a, sel_b;
  logic                last_pass;
  logic                accept;

  assign last_pass = (idx == IDX_W'(NIBBLES - 1));
  assign accept    = in_valid & in_ready;

  zxw_nibble_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_a (
    .data (a_reg),
    .idx  (idx),
    .nib  (sel_a)
  );

  zxw_nibble_sel #(.NIBBLES(NIBBLES), .IDX_W(IDX_W)) u_sel_b (
    .data (b_reg),
    .idx  (idx),
    .nib  (sel_b)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, request handshake and ALU drive; ALU lines idle at zero
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    alu_fs3   = 1'b0;
    alu_fs2   = 1'b0;
    alu_fs1   = 1'b0;
    alu_fs0   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: begin
        in_ready = ~reset;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        alu_a   = sel_a;
        alu_b   = sel_b;
        alu_fs3 = fs_reg[3];
        alu_fs2 = fs_reg[2];
        alu_fs1 = fs_reg[1];
        // Carry chains only for arithmetic passes after the first
        if ((idx != '0) && !fs_reg[FS_LOGIC_BIT]) alu_fs0 = carry_reg;
        else                                      alu_fs0 = fs_reg[FS_CIN_BIT];
        if (last_pass) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-pass result/carry writeback and pass counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      fs_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      if (state == S_IDLE && accept) begin
        fs_reg <= in_fs;
        a_reg  <= in_a;
        b_reg  <= in_b;
        idx    <= '0;
      end
      if (state == S_RUN) begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx == IDX_W'(i)) res_reg[i*NIBBLE_W +: NIBBLE_W] <= alu_result;
        end
        carry_reg <= alu_carryout;
        idx       <= last_pass ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Result side is a straight view of the held registers while in DONE
  assign out_valid  = (state == S_DONE);
  assign out_result = res_reg;
  assign out_carry  = carry_reg;
  assign out_zero   = out_valid & (res_reg == '0);

endmodule

// File: tb/tb_zxw_alu_sequencer.sv
// Self-checking bench for zxw_alu_sequencer with an adder-style ALU stub.
module tb_zxw_alu_sequencer;

  localparam int unsigned NIBBLES = 2;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_fs;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry, out_zero;
  logic         alu_fs3, alu_fs2, alu_fs1, alu_fs0;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic         alu_carryout;
  logic         force_cout;
  logic [4:0]   stub_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ALU stub: nibble add with fs0 as carry-in; force_cout pins carryout high
  assign stub_sum     = 5'(alu_a) + 5'(alu_b) + 5'(alu_fs0);
  assign alu_result   = stub_sum[3:0];
  assign alu_carryout = stub_sum[4] | force_cout;

  zxw_alu_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_fs        (in_fs),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .alu_fs3      (alu_fs3),
    .alu_fs2      (alu_fs2),
    .alu_fs1      (alu_fs1),
    .alu_fs0      (alu_fs0),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  typedef struct {
    logic [3:0]   fs;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   a0, b0, fsv0;
    logic [3:0]   a1, b1, fsv1;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_alu_idle(input string name);
    chk({name, " alu_a"}, 32'(alu_a), 32'h0);
    chk({name, " alu_b"}, 32'(alu_b), 32'h0);
    chk({name, " alu_fs"}, 32'({alu_fs3, alu_fs2, alu_fs1, alu_fs0}), 32'h0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request on the current negedge; returns at the first RUN cycle
  task automatic issue(input logic [3:0] fs, input logic [W-1:0] a, input logic [W-1:0] b);
    chk("in_ready before issue", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    in_fs    = fs;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
    in_fs    = 4'h0;
    in_a     = '0;
    in_b     = '0;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 8'h3C, 8'h45, 4'hC, 4'h5, 4'b0000, 4'h3, 4'h4, 4'b0001, 8'h81, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 8'hFF, 8'h01, 4'hF, 4'h1, 4'b0000, 4'hF, 4'h0, 4'b0001, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{4'b0001, 8'h12, 8'h34, 4'h2, 4'h4, 4'b0001, 4'h1, 4'h3, 4'b0000, 8'h47, 1'b0, 1'b0};
    vecs[3] = '{4'b1010, 8'hF0, 8'h0F, 4'h0, 4'hF, 4'b1010, 4'hF, 4'h0, 4'b1010, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{4'b0110, 8'hA5, 8'h5B, 4'h5, 4'hB, 4'b0110, 4'hA, 4'h5, 4'b0111, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{4'b1111, 8'h00, 8'h00, 4'h0, 4'h0, 4'b1111, 4'h0, 4'h0, 4'b1111, 8'h11, 1'b0, 1'b0};

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_fs      = 4'h0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b0;
    force_cout = 1'b0;

    // Reset held three cycles
    repeat (3) step();
    chk("in_ready during reset", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_result", 32'(out_result), 32'h0);
    chk("reset out_carry", 32'(out_carry), 32'h0);
    chk("reset out_zero", 32'(out_zero), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk_alu_idle("reset");
    step();

    // Table-driven operations with the stub ALU
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].fs, vecs[i].a, vecs[i].b);
      chk("run0 in_ready", 32'(in_ready), 32'h0);
      chk("run0 out_valid", 32'(out_valid), 32'h0);
      chk("run0 alu_a", 32'(alu_a), 32'(vecs[i].a0));
      chk("run0 alu_b", 32'(alu_b), 32'(vecs[i].b0));
      chk("run0 alu_fs", 32'({alu_fs3, alu_fs2, alu_fs1, alu_fs0}), 32'(vecs[i].fsv0));
      step();
      chk("run1 out_valid", 32'(out_valid), 32'h0);
      chk("run1 alu_a", 32'(alu_a), 32'(vecs[i].a1));
      chk("run1 alu_b", 32'(alu_b), 32'(vecs[i].b1));
      chk("run1 alu_fs", 32'({alu_fs3, alu_fs2, alu_fs1, alu_fs0}), 32'(vecs[i].fsv1));
      step();
      chk("done out_valid", 32'(out_valid), 32'h1);
      chk("done out_result", 32'(out_result), 32'(vecs[i].res));
      chk("done out_carry", 32'(out_carry), 32'(vecs[i].carry));
      chk("done out_zero", 32'(out_zero), 32'(vecs[i].zero));
      chk_alu_idle("done");
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("post out_valid", 32'(out_valid), 32'h0);
      chk("post in_ready", 32'(in_ready), 32'h1);
    end

    // Logic op ignores a set carryout from the first pass
    force_cout = 1'b1;
    issue(4'b1010, 8'hF0, 8'h0F);
    chk("lgc run0 alu_fs", 32'({alu_fs3, alu_fs2, alu_fs1, alu_fs0}), 32'hA);
    step();
    chk("lgc run1 alu_fs", 32'({alu_fs3, alu_fs2, alu_fs1, alu_fs0}), 32'hA);
    step();
    force_cout = 1'b0;
    chk("lgc out_result", 32'(out_result), 32'hFF);
    chk("lgc out_carry", 32'(out_carry), 32'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Backpressure: DONE holds, new requests ignored
    issue(4'b0000, 8'h3C, 8'h45);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_fs    = 4'b0001;
      in_a     = 8'h11;
      in_b     = 8'h22;
      #1;
      chk("bp out_valid", 32'(out_valid), 32'h1);
      chk("bp out_result", 32'(out_result), 32'h81);
      chk("bp out_carry", 32'(out_carry), 32'h0);
      chk("bp in_ready", 32'(in_ready), 32'h0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'h0);
    chk("bp release in_ready", 32'(in_ready), 32'h1);
    step();
    chk("bp no second op", 32'(in_ready), 32'h1);
    chk_alu_idle("bp idle");

    // Reset during the second pass discards the operation
    issue(4'b0000, 8'h3C, 8'h45);
    step();
    chk("rst run1 alu_a", 32'(alu_a), 32'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'h1);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk_alu_idle("rst");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst no out_valid", 32'(out_valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
